// File: rtl/spy_serial_rx.sv
// spy_serial_rx: oversampling 8N1 serial receiver feeding the spy port command parser.
//
// Each bit is split into 16 oversample ticks of DIVISOR sysclk cycles each. The bit value
// is the majority of the samples taken on ticks 7, 8 and 9. A start bit that fails its
// vote is rejected as a glitch. A low stop bit raises a frame error and parks the
// receiver in BREAK until the line returns high. Good bytes enter a small FIFO.
//
// Ports:
//   sysclk        in   sole clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   rs232_rxd     in   raw serial line, idle high, LSB first
//   rx_data       out  FIFO head byte, meaningful while rx_valid=1
//   rx_valid      out  FIFO non-empty
//   rx_ack        in   pops the head on a cycle where rx_valid=1
//   rx_overrun    out  sticky: a completed byte was dropped on a full FIFO
//   rx_frame_err  out  sticky: stop bit sampled low
//   err_clr       in   clears both sticky flags (a coincident new error wins)
//   rx_busy       out  receiver not idle (one cycle behind the state)
module spy_serial_rx #(
  parameter int unsigned DIVISOR    = 27,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       sysclk,
  input  logic       reset_n,
  input  logic       rs232_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  input  logic       err_clr,
  output logic       rx_busy
);

  localparam int unsigned AW         = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  TickReload = 8'(DIVISOR - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  logic         r_sync1, r_sync2;
  logic [7:0]   r_tcnt;
  logic [3:0]   r_scnt;
  logic [2:0]   r_bitcnt;
  logic [2:0]   r_smp;
  logic [7:0]   r_shift;
  state_e       r_state;
  logic         r_busy;
  logic         r_frame_err;
  logic         r_overrun;
  logic [7:0]   r_mem [FIFO_DEPTH];
  logic [AW:0]  r_wptr, r_rptr;

  logic w_tick, w_bound, w_vote, w_vote_stop, w_stop_tick;
  logic w_push, w_ferr_set, w_empty, w_full, w_pop, w_wr, w_ovr_set;

  assign w_tick      = (r_tcnt == 8'd0);
  assign w_bound     = w_tick && (r_scnt == 4'd15);
  assign w_vote      = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_smp[2]) | (r_smp[1] & r_smp[2]);
  // The stop decision lands on the third sample's own tick, so that sample is taken live.
  assign w_vote_stop = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_sync2) | (r_smp[1] & r_sync2);
  assign w_stop_tick = (r_state == StStop) && w_tick && (r_scnt == 4'd9);
  assign w_push      = w_stop_tick && w_vote_stop;
  assign w_ferr_set  = w_stop_tick && !w_vote_stop;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop     = rx_ack && !w_empty;
  // A pop in the same cycle frees the slot, so a push onto a full FIFO is still accepted.
  assign w_wr      = w_push && (!w_full || w_pop);
  assign w_ovr_set = w_push && w_full && !w_pop;

  assign rx_data      = r_mem[r_rptr[AW-1:0]];
  assign rx_valid     = !w_empty;
  assign rx_overrun   = r_overrun;
  assign rx_frame_err = r_frame_err;
  assign rx_busy      = r_busy;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rs232_rxd;
      r_sync2 <= r_sync1;
    end
  end

  // Tick divider; reloaded on the start edge so tick phase follows the incoming frame.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_tcnt <= 8'd0;
    end else if ((r_state == StIdle && !r_sync2) || w_tick) begin
      r_tcnt <= TickReload;
    end else begin
      r_tcnt <= r_tcnt - 8'd1;
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_scnt      <= 4'd0;
      r_bitcnt    <= 3'd0;
      r_smp       <= 3'd0;
      r_shift     <= 8'd0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_busy <= (r_state != StIdle);

      if (w_ferr_set) begin
        r_frame_err <= 1'b1;
      end else if (err_clr) begin
        r_frame_err <= 1'b0;
      end

      if (r_state != StIdle && w_tick) begin
        r_scnt <= r_scnt + 4'd1;
        if (r_scnt == 4'd7) r_smp[0] <= r_sync2;
        if (r_scnt == 4'd8) r_smp[1] <= r_sync2;
        if (r_scnt == 4'd9) r_smp[2] <= r_sync2;
      end

      unique case (r_state)
        StIdle: begin
          r_scnt <= 4'd0;
          if (!r_sync2) r_state <= StStart;
        end
        StStart: begin
          if (w_bound) begin
            if (!w_vote) begin
              r_state  <= StData;
              r_bitcnt <= 3'd0;
            end else begin
              r_state <= StIdle;
            end
          end
        end
        StData: begin
          if (w_bound) begin
            r_shift <= {w_vote, r_shift[7:1]};
            if (r_bitcnt == 3'd7) begin
              r_state <= StStop;
            end else begin
              r_bitcnt <= r_bitcnt + 3'd1;
            end
          end
        end
        StStop: begin
          if (w_stop_tick) r_state <= w_vote_stop ? StIdle : StBreak;
        end
        StBreak: begin
          if (r_sync2) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_overrun <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 8'd0;
      end
    end else begin
      if (w_wr) begin
        r_mem[r_wptr[AW-1:0]] <= r_shift;
        r_wptr                <= r_wptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
      end
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (err_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spy_serial_rx.sv
module tb_spy_serial_rx;

  localparam int unsigned Div    = 4;
  localparam int unsigned BitCyc = 16 * Div;
  localparam int unsigned Depth  = 4;

  logic       sysclk = 1'b0;
  logic       reset_n;
  logic       rs232_rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic       err_clr;
  logic       rx_busy;

  always #5 sysclk = ~sysclk;

  spy_serial_rx #(
    .DIVISOR    (Div),
    .FIFO_DEPTH (Depth)
  ) dut (
    .sysclk       (sysclk),
    .reset_n      (reset_n),
    .rs232_rxd    (rs232_rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ack       (rx_ack),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err),
    .err_clr      (err_clr),
    .rx_busy      (rx_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: ideal FIFO contents and expected overrun flag.
  logic [7:0] q[$];
  bit         exp_ovr;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rs232_rxd = 1'b0;
    idle(BitCyc);
    for (int i = 0; i < 8; i++) begin
      rs232_rxd = b[i];
      idle(BitCyc);
    end
    rs232_rxd = stop;
    idle(BitCyc);
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    @(negedge sysclk);
    rx_ack = 1'b0;
  endtask

  task automatic clr_pulse();
    err_clr = 1'b1;
    @(negedge sysclk);
    err_clr = 1'b0;
  endtask

  task automatic model_push(input logic [7:0] b);
    if (q.size() < Depth) q.push_back(b);
    else exp_ovr = 1'b1;
  endtask

  task automatic pop_check(input string name);
    check({name, "_valid"}, rx_valid, 1);
    check({name, "_data"}, rx_data, q[0]);
    void'(q.pop_front());
    ack_pulse();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_data"}, rx_data, 0);
    check({name, "_valid"}, rx_valid, 0);
    check({name, "_ovr"}, rx_overrun, 0);
    check({name, "_ferr"}, rx_frame_err, 0);
    check({name, "_busy"}, rx_busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bit got;
    int nb;
    int k;
    logic [7:0] b;

    vecs[0] = '{data: 8'h55, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h55, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h00, exp_ferr: 1'b0};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'hFF, exp_ferr: 1'b0};
    vecs[3] = '{data: 8'hA3, stop: 1'b0, exp_valid: 1'b0, exp_data: 8'h00, exp_ferr: 1'b1};
    vecs[4] = '{data: 8'h3C, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h3C, exp_ferr: 1'b0};
    vecs[5] = '{data: 8'h81, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h81, exp_ferr: 1'b0};
    vecs[6] = '{data: 8'h00, stop: 1'b0, exp_valid: 1'b0, exp_data: 8'h00, exp_ferr: 1'b1};

    reset_n   = 1'b1;
    rs232_rxd = 1'b1;
    rx_ack    = 1'b0;
    err_clr   = 1'b0;
    #2 reset_n = 1'b0;
    idle(5);
    check_all_zero("reset_held");
    reset_n = 1'b1;
    idle(20);
    check_all_zero("reset_released");

    // Table-driven frames.
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].data, vecs[i].stop);
      if (!vecs[i].stop) idle(300);
      rs232_rxd = 1'b1;
      idle(20);
      check($sformatf("vec%0d_valid", i), rx_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check($sformatf("vec%0d_data", i), rx_data, vecs[i].exp_data);
      check($sformatf("vec%0d_ferr", i), rx_frame_err, vecs[i].exp_ferr);
      check($sformatf("vec%0d_ovr", i), rx_overrun, 0);
      check($sformatf("vec%0d_busy", i), rx_busy, 0);
      if (vecs[i].exp_valid) begin
        ack_pulse();
        check($sformatf("vec%0d_valid_after_ack", i), rx_valid, 0);
      end
      clr_pulse();
      check($sformatf("vec%0d_ferr_cleared", i), rx_frame_err, 0);
    end

    // Start glitch: 10 low cycles must be rejected.
    rs232_rxd = 1'b0;
    idle(8);
    check("glitch_busy_set", rx_busy, 1);
    idle(2);
    rs232_rxd = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 64 && !got; c++) begin
      @(negedge sysclk);
      if (!rx_busy) got = 1'b1;
    end
    check("glitch_busy_clear_in_time", got, 1);
    idle(100);
    check("glitch_valid", rx_valid, 0);
    check("glitch_ferr", rx_frame_err, 0);

    // Break: one frame error only, even if cleared while the line stays low.
    send_frame(8'hA3, 1'b0);
    idle(200);
    check("break_ferr", rx_frame_err, 1);
    check("break_busy", rx_busy, 1);
    clr_pulse();
    idle(300);
    check("break_no_repeat_ferr", rx_frame_err, 0);
    check("break_valid", rx_valid, 0);
    rs232_rxd = 1'b1;
    idle(20);
    check("break_exit_busy", rx_busy, 0);
    send_frame(8'h3C, 1'b1);
    idle(20);
    check("after_break_valid", rx_valid, 1);
    check("after_break_data", rx_data, 8'h3C);
    ack_pulse();
    check("after_break_empty", rx_valid, 0);

    // Overrun and ordering.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    idle(20);
    check("ovr_flag", rx_overrun, 1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ovr_pop%0d_valid", i), rx_valid, 1);
      check($sformatf("ovr_pop%0d_data", i), rx_data, i);
      ack_pulse();
    end
    check("ovr_drained", rx_valid, 0);
    clr_pulse();
    check("ovr_cleared", rx_overrun, 0);

    // Reset in the middle of a frame, with a byte already queued.
    send_frame(8'h77, 1'b1);
    idle(20);
    check("midrst_preload_valid", rx_valid, 1);
    rs232_rxd = 1'b0;
    idle(BitCyc);
    rs232_rxd = 1'b1;
    idle(4 * BitCyc + 20);
    reset_n = 1'b0;
    idle(2);
    check("midrst_valid", rx_valid, 0);
    check("midrst_busy", rx_busy, 0);
    check("midrst_data", rx_data, 0);
    reset_n = 1'b1;
    idle(4 * BitCyc + 200);
    check("midrst_idle_busy", rx_busy, 0);
    check("midrst_idle_valid", rx_valid, 0);
    send_frame(8'h12, 1'b1);
    idle(20);
    check("midrst_next_valid", rx_valid, 1);
    check("midrst_next_data", rx_data, 8'h12);
    ack_pulse();

    // Randomized bursts against the queue model.
    q.delete();
    exp_ovr = 1'b0;
    for (int r = 0; r < 12; r++) begin
      nb = $urandom_range(1, 6);
      for (int j = 0; j < nb; j++) begin
        b = 8'($urandom);
        send_frame(b, 1'b1);
        model_push(b);
      end
      idle(20);
      check($sformatf("rnd%0d_ovr", r), rx_overrun, exp_ovr);
      k = $urandom_range(0, q.size());
      for (int j = 0; j < k; j++) pop_check($sformatf("rnd%0d_pop%0d", r, j));
      check($sformatf("rnd%0d_valid", r), rx_valid, (q.size() != 0));
      clr_pulse();
      exp_ovr = 1'b0;
    end
    while (q.size() != 0) pop_check("rnd_drain");
    check("rnd_final_valid", rx_valid, 0);
    check("rnd_final_ferr", rx_frame_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
